// File: rtl/img_pkg.sv
// Shared image-path types: sequencer states, pixel layout and width helper.
package img_pkg;

    localparam int BYTES_PER_PIX = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        CAP,
        OUT,
        DONE
    } img_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // Counter widths never collapse to zero for 1-pixel dimensions.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/img_read_ctrl_if.sv
// Memory read port plus outgoing valid/ready pixel stream of the frame reader.
interface img_read_ctrl_if #(
    parameter int ADDR_W = 19,
    parameter int XW     = 9,
    parameter int YW     = 9
) ();
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_r;
    logic [7:0]        pix_g;
    logic [7:0]        pix_b;
    logic [XW-1:0]     pix_x;
    logic [YW-1:0]     pix_y;
    logic              pix_last;

    modport master (
        output mem_en, mem_addr, pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_last,
        input  mem_rdata, pix_ready
    );

    modport slave (
        input  mem_en, mem_addr, pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_last,
        output mem_rdata, pix_ready
    );
endinterface

// File: rtl/img_addr_gen.sv
// Multiplier-free pixel address walker: bottom-row-first memory, top-row-first output order.
// Registered counters, one step per accepted pixel; no internal backpressure.
module img_addr_gen
    import img_pkg::*;
#(
    parameter int WIDTH  = 500,
    parameter int HEIGHT = 333,
    parameter int ADDR_W = clog2_min1(BYTES_PER_PIX * WIDTH * HEIGHT),
    parameter int XW     = clog2_min1(WIDTH),
    parameter int YW     = clog2_min1(HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic              last
);
    localparam logic [ADDR_W-1:0] ROW_BYTES = ADDR_W'(BYTES_PER_PIX * WIDTH);
    localparam logic [ADDR_W-1:0] TOP_BASE  = ADDR_W'(BYTES_PER_PIX * WIDTH * (HEIGHT - 1));
    localparam logic [XW-1:0]     X_MAX     = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_MAX     = YW'(HEIGHT - 1);

    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] col_off;
    logic              row_end;

    assign row_end = (x == X_MAX);
    assign last    = row_end && (y == Y_MAX);
    assign addr    = row_base + col_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base <= '0;
            col_off  <= '0;
            x        <= '0;
            y        <= '0;
        end else if (load) begin
            row_base <= TOP_BASE;
            col_off  <= '0;
            x        <= '0;
            y        <= '0;
        end else if (step && !last) begin
            // The final pixel leaves everything alone so row_base cannot underflow.
            if (row_end) begin
                row_base <= row_base - ROW_BYTES;
                col_off  <= '0;
                x        <= '0;
                y        <= y + YW'(1);
            end else begin
                col_off  <= col_off + ADDR_W'(BYTES_PER_PIX);
                x        <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/img_read_ctrl.sv
// Frame-read sequencer: three byte reads per pixel, R/G/B reassembly, raster-order stream.
// First pixel 5 cycles after start, 5 cycles/pixel; OUT holds until pix_ready.
module img_read_ctrl
    import img_pkg::*;
#(
    parameter int WIDTH  = 500,
    parameter int HEIGHT = 333,
    parameter int ADDR_W = clog2_min1(BYTES_PER_PIX * WIDTH * HEIGHT),
    parameter int XW     = clog2_min1(WIDTH),
    parameter int YW     = clog2_min1(HEIGHT)
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    img_read_ctrl_if.master   bus,
    output logic              busy,
    output logic              done
);
    img_state_e        state, state_nxt;
    pixel_t            pix_q;
    logic              armed;
    logic              load, step;
    logic              rd_phase;
    logic [ADDR_W-1:0] base_addr, rd_addr, addr_hold;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              last;

    img_addr_gen #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .ADDR_W(ADDR_W),
        .XW    (XW),
        .YW    (YW)
    ) u_addr_gen (
        .clk  (HCLK),
        .rst_n(HRESETn),
        .load (load),
        .step (step),
        .addr (base_addr),
        .x    (x),
        .y    (y),
        .last (last)
    );

    assign rd_phase = (state == RD0) || (state == RD1) || (state == RD2);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        rd_addr   = base_addr;
        case (state)
            IDLE: begin
                // armed blocks a start seen on the very first edge after reset release.
                if (start && armed) begin
                    load      = 1'b1;
                    state_nxt = RD0;
                end
            end
            RD0:  state_nxt = RD1;
            RD1: begin
                rd_addr   = base_addr + ADDR_W'(1);
                state_nxt = RD2;
            end
            RD2: begin
                rd_addr   = base_addr + ADDR_W'(2);
                state_nxt = CAP;
            end
            CAP:  state_nxt = OUT;
            OUT: begin
                if (bus.pix_ready) begin
                    step      = 1'b1;
                    state_nxt = last ? DONE : RD0;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            armed     <= 1'b0;
            pix_q     <= '0;
            addr_hold <= '0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (rd_phase) addr_hold <= rd_addr;
            // Read data lags mem_en by one cycle, so each byte lands one state later.
            case (state)
                RD1:     pix_q.r <= bus.mem_rdata;
                RD2:     pix_q.g <= bus.mem_rdata;
                CAP:     pix_q.b <= bus.mem_rdata;
                default: ;
            endcase
        end
    end

    assign bus.mem_en    = rd_phase;
    assign bus.mem_addr  = rd_phase ? rd_addr : addr_hold;
    assign bus.pix_valid = (state == OUT);
    assign bus.pix_r     = pix_q.r;
    assign bus.pix_g     = pix_q.g;
    assign bus.pix_b     = pix_q.b;
    assign bus.pix_x     = x;
    assign bus.pix_y     = y;
    assign bus.pix_last  = (state == OUT) && last;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

endmodule

// File: tb/tb_img_read_ctrl.sv
// Bench for img_read_ctrl: a 4x2 frame reader and a 1x1 frame reader against a raster-order reference.
module tb_img_read_ctrl;
    import img_pkg::*;

    localparam int WA    = 4;
    localparam int HA    = 2;
    localparam int NPIX  = WA * HA;
    localparam int AW_A  = clog2_min1(3 * WA * HA);
    localparam int XW_A  = clog2_min1(WA);
    localparam int YW_A  = clog2_min1(HA);
    localparam int AW_B  = clog2_min1(3);

    logic       clk;
    logic       rst_n;
    logic       a_start, b_start;
    logic       a_busy, a_done, b_busy, b_done;
    logic [7:0] mem_key;
    int         n_cmp;
    int         n_bad;

    img_read_ctrl_if #(.ADDR_W(AW_A), .XW(XW_A), .YW(YW_A)) ia ();
    img_read_ctrl_if #(.ADDR_W(AW_B), .XW(1), .YW(1)) ib ();

    img_read_ctrl #(.WIDTH(WA), .HEIGHT(HA)) u_dut_a (
        .HCLK(clk), .HRESETn(rst_n), .start(a_start), .bus(ia), .busy(a_busy), .done(a_done)
    );

    img_read_ctrl #(.WIDTH(1), .HEIGHT(1)) u_dut_b (
        .HCLK(clk), .HRESETn(rst_n), .start(b_start), .bus(ib), .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous image memories: byte content is the address, optionally scrambled by a key.
    always @(posedge clk) if (ia.mem_en) ia.mem_rdata <= 8'(ia.mem_addr) ^ mem_key;
    always @(posedge clk) if (ib.mem_en) ib.mem_rdata <= 8'(ib.mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full 4x2 frame; ready pattern chosen by the mode flags.
    task automatic run_frame(input logic [7:0] key, input bit stall1, input bit rnd, input bit repulse);
        int cyc, n, hs_prev, last_hs, done_cnt, done_cyc, en_cnt, stall;
        int i, j, base;
        bit seen, rdy;
        cyc = 0; n = 0; hs_prev = 0; last_hs = -1; done_cnt = 0; done_cyc = -100;
        en_cnt = 0; stall = 0; seen = 1'b0;
        mem_key = key;
        @(negedge clk);
        a_start = 1'b1;
        while (cyc < 400 && !(done_cnt > 0 && cyc >= done_cyc + 3)) begin
            @(negedge clk);
            cyc++;
            a_start = 1'b0;
            if (repulse && cyc == 12) a_start = 1'b1;
            if (ia.mem_en) en_cnt++;
            if (a_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_in_done", a_busy, 1);
                if (repulse) a_start = 1'b1;
            end
            rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (ia.pix_valid) begin
                if (n >= NPIX) begin
                    chk("extra_valid", ia.pix_valid, 0);
                end else begin
                    i    = n / WA;
                    j    = n % WA;
                    base = 3 * WA * (HA - 1 - i) + 3 * j;
                    if (!seen) begin
                        seen = 1'b1;
                        chk("valid_gap", cyc - hs_prev, 5);
                    end
                    chk("pix_r", ia.pix_r, 8'(base) ^ key);
                    chk("pix_g", ia.pix_g, 8'(base + 1) ^ key);
                    chk("pix_b", ia.pix_b, 8'(base + 2) ^ key);
                    chk("pix_x", ia.pix_x, j);
                    chk("pix_y", ia.pix_y, i);
                    chk("pix_last", ia.pix_last, (n == NPIX - 1) ? 1 : 0);
                    chk("mem_en_in_out", ia.mem_en, 0);
                    if (stall1 && n == 1 && stall < 3) begin
                        rdy = 1'b0;
                        stall++;
                    end
                end
                if (rdy) begin
                    hs_prev = cyc;
                    last_hs = cyc;
                    n++;
                    seen = 1'b0;
                end
            end
            ia.pix_ready = rdy;
        end
        chk("frame_timeout", (cyc < 400) ? 1 : 0, 1);
        chk("handshakes", n, NPIX);
        chk("done_count", done_cnt, 1);
        chk("done_after_last", done_cyc, last_hs + 1);
        chk("mem_en_count", en_cnt, 3 * NPIX);
        chk("busy_after", a_busy, 0);
        ia.pix_ready = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        mem_key = 8'd0;
        ia.pix_ready = 1'b1;
        ib.pix_ready = 1'b1;

        #1;
        chk("rst_valid", ia.pix_valid, 0);
        chk("rst_mem_en", ia.mem_en, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_addr", ia.mem_addr, 0);
        chk("rst_pix_r", ia.pix_r, 0);
        chk("rst_last", ia.pix_last, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(8'd0, 1'b0, 1'b0, 1'b0);
        run_frame(8'd0, 1'b1, 1'b0, 1'b0);
        run_frame(8'd0, 1'b0, 1'b0, 1'b1);

        // 1x1 frame, cycle by cycle.
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("b_en0", ib.mem_en, 1);
        chk("b_addr0", ib.mem_addr, 0);
        @(negedge clk);
        chk("b_en1", ib.mem_en, 1);
        chk("b_addr1", ib.mem_addr, 1);
        @(negedge clk);
        chk("b_en2", ib.mem_en, 1);
        chk("b_addr2", ib.mem_addr, 2);
        @(negedge clk);
        chk("b_en_cap", ib.mem_en, 0);
        chk("b_valid_early", ib.pix_valid, 0);
        @(negedge clk);
        chk("b_valid", ib.pix_valid, 1);
        chk("b_r", ib.pix_r, 0);
        chk("b_g", ib.pix_g, 1);
        chk("b_b", ib.pix_b, 2);
        chk("b_last", ib.pix_last, 1);
        @(negedge clk);
        chk("b_done", b_done, 1);
        chk("b_valid_after", ib.pix_valid, 0);
        @(negedge clk);
        chk("b_done_pulse", b_done, 0);
        chk("b_busy_after", b_busy, 0);

        // Reset in the middle of a pixel read.
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        chk("rd1_en", ia.mem_en, 1);
        chk("rd1_addr", ia.mem_addr, 13);
        chk("rd1_busy", a_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en", ia.mem_en, 0);
        chk("midrst_valid", ia.pix_valid, 0);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_addr", ia.mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("start_at_release", a_busy, 0);
        run_frame(8'($urandom), 1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 3; f++) begin
            run_frame(8'($urandom), 1'b0, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
